// File: rtl/nucore_pkg.sv
// Shared Nucore definitions: instruction word layout, opcodes, issue states.
package nucore_pkg;

    localparam int INSTR_W = 39;
    localparam int OPC_W   = 3;
    localparam int OPND_W  = 36;

    localparam logic [OPC_W-1:0] OPC_NOP = 3'b000;
    localparam logic [OPC_W-1:0] OPC_WRA = 3'b001;
    localparam logic [OPC_W-1:0] OPC_WRB = 3'b010;

    // All-zero word: opcode NOP, so the decoder performs no register write.
    localparam logic [INSTR_W-1:0] NOP_WORD = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } issue_state_t;

    // Opcode occupies the top bits, operand the rest.
    function automatic logic [INSTR_W-1:0] pack_instr(
        input logic [OPC_W-1:0]  opcode,
        input logic [OPND_W-1:0] operand
    );
        return {opcode, operand};
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous instruction FIFO. Head word is read combinationally from the
// registered read pointer; flags are decoded from the registered level.
module instr_fifo
    import nucore_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [INSTR_W-1:0] push_data,
    input  logic               pop,
    output logic [INSTR_W-1:0] head,
    output logic [LVL_W-1:0]   level,
    output logic               full,
    output logic               empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [INSTR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               push_ok;
    logic               pop_ok;

    // Requests are qualified here as well so the FIFO can never over/underflow.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign full  = (level == LVL_W'(DEPTH));
    assign empty = (level == '0);
    assign head  = mem[rd_ptr];

    // Storage array: written at the tail, no reset needed.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_data;
    end

    // Pointer and occupancy tracking; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/instr_issue.sv
// Instruction issue unit: packs host writes into instruction words, buffers
// them, and issues one per cycle under an IDLE/RUN/STEP control machine.
// The bus falls back to NOP whenever nothing is popped, so a stall never
// replays a word to the decoder.
module instr_issue
    import nucore_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   WrValid,
    output logic                   WrReady,
    input  logic [OPC_W-1:0]       WrOpcode,
    input  logic [OPND_W-1:0]      WrOperand,
    input  logic                   Run,
    input  logic                   Step,
    input  logic                   Stop,
    input  logic                   Hold,
    output logic [INSTR_W-1:0]     Instruction,
    output logic                   InstrValid,
    output logic                   Empty,
    output logic                   Full,
    output logic [$clog2(DEPTH):0] Level,
    output logic [CNT_W-1:0]       IssueCount
);

    issue_state_t       state;
    issue_state_t       state_next;
    logic [INSTR_W-1:0] head;
    logic               push;
    logic               pop;

    assign WrReady = !Full;
    assign push    = WrValid && WrReady;

    // Pop decision uses the registered state only; commands land next cycle.
    assign pop = (state == RUN || state == STEP) && !Empty && !Hold;

    instr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (Clk),
        .rst       (Rst),
        .push      (push),
        .push_data (pack_instr(WrOpcode, WrOperand)),
        .pop       (pop),
        .head      (head),
        .level     (Level),
        .full      (Full),
        .empty     (Empty)
    );

    // Control state register.
    always_ff @(posedge Clk) begin
        if (Rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next state: a completed single step falls back to IDLE, then the host
    // commands override with priority Stop > Step > Run.
    always_comb begin
        state_next = state;
        if (state == STEP && pop)
            state_next = IDLE;
        if (Stop)
            state_next = IDLE;
        else if (Step)
            state_next = STEP;
        else if (Run)
            state_next = RUN;
    end

    // Output register and issue counter: real word on a pop, NOP otherwise.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Instruction <= NOP_WORD;
            InstrValid  <= 1'b0;
            IssueCount  <= '0;
        end else begin
            InstrValid <= pop;
            if (pop) begin
                Instruction <= head;
                IssueCount  <= IssueCount + CNT_W'(1);
            end else begin
                Instruction <= NOP_WORD;
            end
        end
    end

endmodule

// File: tb/tb_instr_issue.sv
// Randomized and directed bench for instr_issue against a queue-based model.
module tb_instr_issue;

    localparam int DEPTH = 8;
    localparam int CNT_W = 16;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        WrValid = 1'b0;
    logic        WrReady;
    logic [2:0]  WrOpcode = '0;
    logic [35:0] WrOperand = '0;
    logic        Run = 1'b0, Step = 1'b0, Stop = 1'b0, Hold = 1'b0;
    logic [38:0] Instruction;
    logic        InstrValid, Empty, Full;
    logic [3:0]  Level;
    logic [15:0] IssueCount;

    int vectors = 0;
    int miscompares = 0;

    instr_issue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Rst(Rst), .WrValid(WrValid), .WrReady(WrReady),
        .WrOpcode(WrOpcode), .WrOperand(WrOperand), .Run(Run), .Step(Step),
        .Stop(Stop), .Hold(Hold), .Instruction(Instruction),
        .InstrValid(InstrValid), .Empty(Empty), .Full(Full), .Level(Level),
        .IssueCount(IssueCount)
    );

    always #5 Clk = ~Clk;

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2;
    logic [38:0] q[$];
    int          m_mode = M_IDLE;
    logic [38:0] m_instr = '0;
    logic        m_valid = 1'b0;
    logic [15:0] m_count = '0;

    function automatic logic [62:0] model_vec();
        return {m_instr, m_valid, m_count, 4'(q.size()),
                q.size() == DEPTH, q.size() == 0, q.size() != DEPTH};
    endfunction

    function automatic logic [62:0] dut_vec();
        return {Instruction, InstrValid, IssueCount, Level, Full, Empty, WrReady};
    endfunction

    function automatic logic [38:0] rnd_word();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[38:0];
    endfunction

    // Apply one cycle of inputs, advance the model alongside the DUT edge.
    task automatic tick(input logic rst, input logic wv, input logic [38:0] w,
                        input logic run, input logic step, input logic stop,
                        input logic hold);
        bit do_pop, do_push;
        Rst = rst; WrValid = wv; WrOpcode = w[38:36]; WrOperand = w[35:0];
        Run = run; Step = step; Stop = stop; Hold = hold;
        do_pop  = (m_mode != M_IDLE) && (q.size() > 0) && !hold;
        do_push = wv && (q.size() < DEPTH);
        @(posedge Clk);
        #1;
        if (rst) begin
            q.delete(); m_mode = M_IDLE; m_instr = '0; m_valid = 0; m_count = '0;
        end else begin
            m_valid = do_pop;
            m_instr = do_pop ? q[0] : 39'b0;
            if (do_pop) begin
                m_count = m_count + 16'd1;
                void'(q.pop_front());
            end
            if (do_push) q.push_back(w);
            if (stop)                           m_mode = M_IDLE;
            else if (step)                      m_mode = M_STEP;
            else if (run)                       m_mode = M_RUN;
            else if (m_mode == M_STEP && do_pop) m_mode = M_IDLE;
        end
    endtask

    task automatic idle_tick(); tick(0, 0, '0, 0, 0, 0, 0); endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        tick(1, 0, '0, 1, 0, 0, 0);
        tick(1, 0, '0, 1, 0, 0, 0);
        vectors++;
        if ({Instruction, InstrValid, IssueCount, WrReady, Level, Empty} !==
            {39'b0, 1'b0, 16'b0, 1'b1, 4'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset got instr=%h v=%b cnt=%0d rdy=%b lvl=%0d want zeros/ready", Instruction, InstrValid, IssueCount, WrReady, Level);
        end
        idle_tick();
        vectors++;
        if (dut_vec() !== model_vec()) begin
            miscompares++; $display("FAIL reset_idle got %h want %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_two_words();
        logic [38:0] exp_bus[3];
        logic        exp_v[3];
        exp_bus[0] = {3'b001, 36'h5}; exp_v[0] = 1;
        exp_bus[1] = {3'b010, 36'h7}; exp_v[1] = 1;
        exp_bus[2] = 39'b0;           exp_v[2] = 0;
        tick(0, 1, {3'b001, 36'h5}, 0, 0, 0, 0);
        tick(0, 1, {3'b010, 36'h7}, 0, 0, 0, 0);
        tick(0, 0, '0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            idle_tick();
            vectors++;
            if (Instruction !== exp_bus[i] || InstrValid !== exp_v[i]) begin
                miscompares++;
                $display("FAIL two_words[%0d] got %h/%b want %h/%b", i, Instruction, InstrValid, exp_bus[i], exp_v[i]);
            end
        end
        vectors++;
        if (IssueCount !== 16'd2) begin
            miscompares++; $display("FAIL two_words_count got %0d want 2", IssueCount);
        end
        tick(0, 0, '0, 0, 0, 1, 0);
    endtask

    task automatic test_fill();
        logic [38:0] w[9];
        logic [38:0] got[$];
        for (int i = 0; i < 9; i++) w[i] = rnd_word();
        for (int i = 0; i < 9; i++) begin
            tick(0, 1, w[i], 0, 0, 0, 0);
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++; $display("FAIL fill[%0d] got %h want %h", i, dut_vec(), model_vec());
            end
        end
        vectors++;
        if (Full !== 1'b1 || WrReady !== 1'b0 || Level !== 4'd8) begin
            miscompares++; $display("FAIL fill_flags got full=%b rdy=%b lvl=%0d want 1/0/8", Full, WrReady, Level);
        end
        tick(0, 0, '0, 1, 0, 0, 0);
        for (int i = 0; i < 11; i++) begin
            idle_tick();
            if (InstrValid) got.push_back(Instruction);
        end
        vectors++;
        if (got.size() != 8) begin
            miscompares++; $display("FAIL fill_issue_count got %0d want 8", got.size());
        end
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            vectors++;
            if (got[i] !== w[i]) begin
                miscompares++; $display("FAIL fill_order[%0d] got %h want %h", i, got[i], w[i]);
            end
        end
        tick(0, 0, '0, 0, 0, 1, 0);
    endtask

    task automatic test_step();
        int issued = 0;
        for (int i = 0; i < 3; i++) tick(0, 1, rnd_word(), 0, 0, 0, 0);
        tick(0, 0, '0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin idle_tick(); issued += int'(InstrValid); end
        tick(0, 0, '0, 0, 1, 0, 0);
        issued += int'(InstrValid);
        for (int i = 0; i < 4; i++) begin
            idle_tick(); issued += int'(InstrValid);
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++; $display("FAIL step_cyc[%0d] got %h want %h", i, dut_vec(), model_vec());
            end
        end
        vectors++;
        if (issued != 2 || Level !== 4'd1) begin
            miscompares++; $display("FAIL step got issued=%0d lvl=%0d want 2/1", issued, Level);
        end
        tick(0, 0, '0, 1, 0, 0, 0);
        idle_tick(); idle_tick();
        tick(0, 0, '0, 0, 0, 1, 0);
    endtask

    task automatic test_hold();
        logic [38:0] w[10];
        logic [38:0] got[$];
        tick(0, 0, '0, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            w[i] = rnd_word();
            tick(0, 1, w[i], 0, 0, 0, (i >= 3 && i < 6));
            if (InstrValid) got.push_back(Instruction);
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++; $display("FAIL hold_cyc[%0d] got %h want %h", i, dut_vec(), model_vec());
            end
            if (i >= 3 && i < 6) begin
                vectors++;
                if (Instruction !== 39'b0 || InstrValid !== 1'b0) begin
                    miscompares++; $display("FAIL hold_bus[%0d] got %h/%b want 0/0", i, Instruction, InstrValid);
                end
            end
        end
        for (int i = 0; i < 6; i++) begin idle_tick(); if (InstrValid) got.push_back(Instruction); end
        vectors++;
        if (got.size() != 10) begin
            miscompares++; $display("FAIL hold_count got %0d want 10", got.size());
        end
        for (int i = 0; i < 10 && i < got.size(); i++) begin
            vectors++;
            if (got[i] !== w[i]) begin
                miscompares++; $display("FAIL hold_order[%0d] got %h want %h", i, got[i], w[i]);
            end
        end
        tick(0, 0, '0, 0, 0, 1, 0);
    endtask

    task automatic test_priority();
        for (int i = 0; i < 6; i++) tick(0, 1, rnd_word(), 0, 0, 0, 0);
        tick(0, 0, '0, 1, 0, 0, 0);
        tick(0, 0, '0, 1, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            idle_tick();
            vectors++;
            if (InstrValid !== 1'b0 || dut_vec() !== model_vec()) begin
                miscompares++; $display("FAIL prio_idle[%0d] got %h want %h", i, dut_vec(), model_vec());
            end
        end
        vectors++;
        if (Level !== 4'd5) begin
            miscompares++; $display("FAIL prio_level got %0d want 5", Level);
        end
        tick(1, 0, '0, 0, 0, 0, 0);
        vectors++;
        if (Level !== 4'd0 || Empty !== 1'b1 || IssueCount !== 16'd0) begin
            miscompares++; $display("FAIL midreset got lvl=%0d empty=%b cnt=%0d want 0/1/0", Level, Empty, IssueCount);
        end
        idle_tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(63) == 0), ($urandom_range(9) < 7), rnd_word(),
                 ($urandom_range(9) == 0), ($urandom_range(9) == 0),
                 ($urandom_range(19) == 0), ($urandom_range(4) == 0));
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++; $display("FAIL random[%0d] got %h want %h", i, dut_vec(), model_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_fill();
        test_step();
        test_hold();
        test_priority();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
